// File: rtl/alu_regfile_pkg.sv
// Shared widths, flag bit positions and ALU control codes for the
// register-file / ALU datapath.
package alu_regfile_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int FLAG_W   = 3;
   localparam int NUM_REGS = 2 ** ADDR_W;

   // Bit positions inside the {Co, zero, overflow} status word
   localparam int FLAG_CO   = 2;
   localparam int FLAG_ZERO = 1;
   localparam int FLAG_OVF  = 0;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [FLAG_W-1:0] flags_t;

   // ALU_Ctr encodings driven by the instruction controller
   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_NOR = 4'b1100
   } alu_ctr_e;

   function automatic flags_t pack_flags(input logic co, input logic zero, input logic ovf);
      flags_t f;
      f            = '0;
      f[FLAG_CO]   = co;
      f[FLAG_ZERO] = zero;
      f[FLAG_OVF]  = ovf;
      return f;
   endfunction

endpackage

// File: rtl/alu_regfile_if.sv
// Controller/ALU-side bus of the register file: operand reads, issue,
// write-back, flag capture and the debug read port.
interface alu_regfile_if;
   import alu_regfile_pkg::*;

   addr_t  r_addr_a;
   addr_t  r_addr_b;
   data_t  r_data_a;
   data_t  r_data_b;
   logic   pend_a;
   logic   pend_b;
   logic   iss_valid;
   addr_t  iss_addr;
   logic   wb_valid;
   addr_t  wb_addr;
   data_t  wb_data;
   logic   flag_we;
   flags_t flag_in;
   flags_t flags;
   addr_t  dbg_addr;
   data_t  dbg_data;

   modport master (
      output r_addr_a, r_addr_b, iss_valid, iss_addr, wb_valid, wb_addr, wb_data,
             flag_we, flag_in, dbg_addr,
      input  r_data_a, r_data_b, pend_a, pend_b, flags, dbg_data
   );

   modport slave (
      input  r_addr_a, r_addr_b, iss_valid, iss_addr, wb_valid, wb_addr, wb_data,
             flag_we, flag_in, dbg_addr,
      output r_data_a, r_data_b, pend_a, pend_b, flags, dbg_data
   );

endinterface

// File: rtl/alu_regfile_scoreboard.sv
// Pending-destination scoreboard: one bit per register marking a result
// still in flight, looked up for both operand ports.
module regfile_scoreboard
   import alu_regfile_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  iss_valid_i,
   input  addr_t iss_addr_i,
   input  logic  wb_valid_i,
   input  addr_t wb_addr_i,
   input  addr_t r_addr_a_i,
   input  addr_t r_addr_b_i,
   output logic  pend_a_o,
   output logic  pend_b_o
);

   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_d;

   // Clear first, then set, so an issue to the address being written back wins.
   always_comb begin
      // NOTE: pending_d takes a full default before any conditional update,
      // so no path leaves it unassigned and no latch is inferred.
      pending_d = pending_q;
      if (wb_valid_i) begin
         pending_d[wb_addr_i] = 1'b0;
      end
      if (iss_valid_i) begin
         pending_d[iss_addr_i] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         // NOTE: sequential state is updated with non-blocking assignments so
         // every flop samples the pre-edge values regardless of block order.
         pending_q <= pending_d;
      end
   end

   // A write-back in this cycle resolves the hazard it would otherwise report.
   assign pend_a_o = pending_q[r_addr_a_i] & ~(wb_valid_i && (wb_addr_i == r_addr_a_i));
   assign pend_b_o = pending_q[r_addr_b_i] & ~(wb_valid_i && (wb_addr_i == r_addr_b_i));

endmodule

// File: rtl/alu_regfile.sv
// Register file for the 32-bit ALU datapath: two bypassed operand reads,
// one write-back port, status flags, RAW scoreboard and a debug read.
module alu_regfile
   import alu_regfile_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   alu_regfile_if.slave bus
);

   data_t  regs_q [NUM_REGS];
   flags_t flags_q;
   flags_t flags_d;
   logic   wb_hit;

   assign wb_hit = bus.wb_valid && (bus.wb_addr != '0);

   // NOTE: the array sits under reset because every register must read zero
   // straight after reset; that forces flop storage rather than a RAM macro.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (wb_hit && (bus.wb_addr == ADDR_W'(i))) begin
               regs_q[i] <= bus.wb_data;
            end
         end
      end
   end

   assign flags_d = bus.flag_we ? bus.flag_in : flags_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   // Write-first bypass on the operand ports; the debug port shows committed state only.
   assign bus.r_data_a = (wb_hit && (bus.wb_addr == bus.r_addr_a)) ? bus.wb_data
                                                                   : regs_q[bus.r_addr_a];
   assign bus.r_data_b = (wb_hit && (bus.wb_addr == bus.r_addr_b)) ? bus.wb_data
                                                                   : regs_q[bus.r_addr_b];
   assign bus.dbg_data = regs_q[bus.dbg_addr];
   assign bus.flags    = flags_q;

   regfile_scoreboard u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .iss_valid_i (bus.iss_valid),
      .iss_addr_i  (bus.iss_addr),
      .wb_valid_i  (bus.wb_valid),
      .wb_addr_i   (bus.wb_addr),
      .r_addr_a_i  (bus.r_addr_a),
      .r_addr_b_i  (bus.r_addr_b),
      .pend_a_o    (bus.pend_a),
      .pend_b_o    (bus.pend_b)
   );

endmodule

// File: tb/tb_alu_regfile.sv
// Directed self-checking bench for alu_regfile.
module tb_alu_regfile;
   import alu_regfile_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   alu_regfile_if bus ();

   alu_regfile dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      bus.r_addr_a  = '0;
      bus.r_addr_b  = '0;
      bus.iss_valid = 1'b0;
      bus.iss_addr  = '0;
      bus.wb_valid  = 1'b0;
      bus.wb_addr   = '0;
      bus.wb_data   = '0;
      bus.flag_we   = 1'b0;
      bus.flag_in   = '0;
      bus.dbg_addr  = '0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle();
      bus.r_addr_a = 5'd3;
      #12;
      n_checks++;
      if (bus.r_data_a !== 32'h0) begin
         $display("FAIL reset_rdata: got %h required %h", bus.r_data_a, 32'h0);
         n_fail++;
      end
      n_checks++;
      if (bus.flags !== 3'b000 || bus.pend_a !== 1'b0) begin
         $display("FAIL reset_flags_pend: got flags=%b pend=%b required 000/0", bus.flags, bus.pend_a);
         n_fail++;
      end
      rst = 1'b0;
      step();
      // Load reg3, flags and a pending bit, then reset mid-cycle
      bus.wb_valid  = 1'b1;
      bus.wb_addr   = 5'd3;
      bus.wb_data   = 32'h1234;
      bus.flag_we   = 1'b1;
      bus.flag_in   = 3'b111;
      bus.iss_valid = 1'b1;
      bus.iss_addr  = 5'd6;
      step();
      idle();
      bus.r_addr_a = 5'd3;
      bus.r_addr_b = 5'd6;
      bus.dbg_addr = 5'd3;
      #1;
      n_checks++;
      if (bus.r_data_a !== 32'h1234 || bus.pend_b !== 1'b1 || bus.flags !== 3'b111) begin
         $display("FAIL pre_reset_state: got data=%h pend=%b flags=%b required 00001234/1/111",
                  bus.r_data_a, bus.pend_b, bus.flags);
         n_fail++;
      end
      #1;
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.r_data_a !== 32'h0 || bus.dbg_data !== 32'h0) begin
         $display("FAIL async_reset_data: got r=%h dbg=%h required 0/0", bus.r_data_a, bus.dbg_data);
         n_fail++;
      end
      n_checks++;
      if (bus.flags !== 3'b000 || bus.pend_b !== 1'b0 || bus.pend_a !== 1'b0) begin
         $display("FAIL async_reset_state: got flags=%b pend_a=%b pend_b=%b required 000/0/0",
                  bus.flags, bus.pend_a, bus.pend_b);
         n_fail++;
      end
      #2;
      rst = 1'b0;
      step();
   endtask

   task automatic test_r0_write;
      idle();
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd0;
      bus.wb_data  = 32'hFFFF_FFFF;
      bus.r_addr_a = 5'd0;
      #1;
      n_checks++;
      if (bus.r_data_a !== 32'h0) begin
         $display("FAIL r0_no_bypass: got %h required %h", bus.r_data_a, 32'h0);
         n_fail++;
      end
      step();
      bus.wb_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.r_data_a !== 32'h0 || bus.dbg_data !== 32'h0) begin
         $display("FAIL r0_discard: got r=%h dbg=%h required 0/0", bus.r_data_a, bus.dbg_data);
         n_fail++;
      end
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd7;
      bus.wb_data  = 32'hA5A5_A5A5;
      step();
      idle();
      bus.r_addr_b = 5'd7;
      bus.dbg_addr = 5'd7;
      #1;
      n_checks++;
      if (bus.r_data_b !== 32'hA5A5_A5A5 || bus.dbg_data !== 32'hA5A5_A5A5) begin
         $display("FAIL write_r7: got r=%h dbg=%h required a5a5a5a5", bus.r_data_b, bus.dbg_data);
         n_fail++;
      end
      n_checks++;
      if (bus.pend_b !== 1'b0) begin
         $display("FAIL wb_nonpending: got pend=%b required 0", bus.pend_b);
         n_fail++;
      end
   endtask

   task automatic test_bypass;
      idle();
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd5;
      bus.wb_data  = 32'h11;
      step();
      bus.wb_data  = 32'h22;
      bus.r_addr_a = 5'd5;
      bus.r_addr_b = 5'd7;
      bus.dbg_addr = 5'd5;
      #1;
      n_checks++;
      if (bus.r_data_a !== 32'h22) begin
         $display("FAIL bypass_a: got %h required %h", bus.r_data_a, 32'h22);
         n_fail++;
      end
      n_checks++;
      if (bus.dbg_data !== 32'h11 || bus.r_data_b !== 32'hA5A5_A5A5) begin
         $display("FAIL bypass_other: got dbg=%h rb=%h required 00000011/a5a5a5a5",
                  bus.dbg_data, bus.r_data_b);
         n_fail++;
      end
      step();
      bus.wb_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.dbg_data !== 32'h22 || bus.r_data_a !== 32'h22) begin
         $display("FAIL bypass_commit: got dbg=%h ra=%h required 00000022", bus.dbg_data, bus.r_data_a);
         n_fail++;
      end
   endtask

   task automatic test_scoreboard;
      idle();
      bus.iss_valid = 1'b1;
      bus.iss_addr  = 5'd9;
      step();
      idle();
      bus.r_addr_a = 5'd9;
      #1;
      n_checks++;
      if (bus.pend_a !== 1'b1 || bus.pend_b !== 1'b0) begin
         $display("FAIL sb_set: got pend_a=%b pend_b=%b required 1/0", bus.pend_a, bus.pend_b);
         n_fail++;
      end
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd9;
      bus.wb_data  = 32'h99;
      #1;
      n_checks++;
      if (bus.pend_a !== 1'b0) begin
         $display("FAIL sb_wb_comb_clear: got %b required 0", bus.pend_a);
         n_fail++;
      end
      step();
      idle();
      bus.r_addr_a = 5'd9;
      #1;
      n_checks++;
      if (bus.pend_a !== 1'b0 || bus.r_data_a !== 32'h99) begin
         $display("FAIL sb_cleared: got pend=%b data=%h required 0/00000099", bus.pend_a, bus.r_data_a);
         n_fail++;
      end
      bus.iss_valid = 1'b1;
      bus.iss_addr  = 5'd0;
      step();
      idle();
      #1;
      n_checks++;
      if (bus.pend_a !== 1'b0) begin
         $display("FAIL sb_r0_ignored: got %b required 0", bus.pend_a);
         n_fail++;
      end
   endtask

   task automatic test_set_clear;
      idle();
      bus.iss_valid = 1'b1;
      bus.iss_addr  = 5'd4;
      step();
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd4;
      bus.wb_data  = 32'h44;
      step();
      idle();
      bus.r_addr_a = 5'd4;
      #1;
      n_checks++;
      if (bus.pend_a !== 1'b1 || bus.r_data_a !== 32'h44) begin
         $display("FAIL set_wins: got pend=%b data=%h required 1/00000044", bus.pend_a, bus.r_data_a);
         n_fail++;
      end
      bus.iss_valid = 1'b1;
      bus.iss_addr  = 5'd0;
      bus.wb_valid  = 1'b1;
      bus.wb_addr   = 5'd4;
      bus.wb_data   = 32'h45;
      step();
      idle();
      bus.r_addr_a = 5'd4;
      #1;
      n_checks++;
      if (bus.pend_a !== 1'b0 || bus.r_data_a !== 32'h45) begin
         $display("FAIL clear_iss0: got pend=%b data=%h required 0/00000045", bus.pend_a, bus.r_data_a);
         n_fail++;
      end
      // Set and clear on different addresses in one cycle
      bus.iss_valid = 1'b1;
      bus.iss_addr  = 5'd11;
      step();
      bus.iss_addr  = 5'd12;
      bus.wb_valid  = 1'b1;
      bus.wb_addr   = 5'd11;
      bus.wb_data   = 32'hB;
      step();
      idle();
      bus.r_addr_a = 5'd11;
      bus.r_addr_b = 5'd12;
      #1;
      n_checks++;
      if (bus.pend_a !== 1'b0 || bus.pend_b !== 1'b1) begin
         $display("FAIL diff_set_clear: got pend11=%b pend12=%b required 0/1", bus.pend_a, bus.pend_b);
         n_fail++;
      end
   endtask

   task automatic test_flags;
      idle();
      bus.flag_we = 1'b1;
      bus.flag_in = 3'b101;
      step();
      n_checks++;
      if (bus.flags !== 3'b101) begin
         $display("FAIL flags_capture: got %b required 101", bus.flags);
         n_fail++;
      end
      bus.flag_we = 1'b0;
      bus.flag_in = 3'b010;
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd13;
      bus.wb_data  = 32'hD;
      step();
      n_checks++;
      if (bus.flags !== 3'b101) begin
         $display("FAIL flags_hold: got %b required 101", bus.flags);
         n_fail++;
      end
      idle();
      bus.flag_we = 1'b1;
      bus.flag_in = pack_flags(1'b0, 1'b1, 1'b0);
      step();
      idle();
      n_checks++;
      if (bus.flags !== 3'b010) begin
         $display("FAIL flags_zero_only: got %b required 010", bus.flags);
         n_fail++;
      end
   endtask

   task automatic test_back_to_back;
      idle();
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd20;
      bus.wb_data  = 32'hCAFE_0001;
      step();
      bus.wb_addr  = 5'd21;
      bus.wb_data  = 32'hCAFE_0002;
      bus.r_addr_a = 5'd20;
      bus.r_addr_b = 5'd21;
      bus.dbg_addr = 5'd21;
      #1;
      n_checks++;
      if (bus.r_data_a !== 32'hCAFE_0001 || bus.r_data_b !== 32'hCAFE_0002) begin
         $display("FAIL b2b_reads: got a=%h b=%h required cafe0001/cafe0002", bus.r_data_a, bus.r_data_b);
         n_fail++;
      end
      n_checks++;
      if (bus.dbg_data !== 32'h0) begin
         $display("FAIL b2b_dbg_uncommitted: got %h required 0", bus.dbg_data);
         n_fail++;
      end
      step();
      idle();
      bus.dbg_addr = 5'd21;
      #1;
      n_checks++;
      if (bus.dbg_data !== 32'hCAFE_0002) begin
         $display("FAIL b2b_dbg_commit: got %h required cafe0002", bus.dbg_data);
         n_fail++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_r0_write();
      test_bypass();
      test_scoreboard();
      test_set_clear();
      test_flags();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
